// File: rtl/phase_timer.sv
// phase_timer
//   Timebase counter for the traffic light controller. A prescaler divides the
//   clock by PRESCALE into count steps; each step advances a 4-bit phase count
//   while enable_count is high. The count saturates at 15 and never wraps.
//
// Parameters
//   PRESCALE      clock cycles per count step (>= 1)
//   PS_WIDTH      prescaler width, 2**PS_WIDTH > PRESCALE-1
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous reset, active low
//   reset_count   synchronous clear, active high, wins over enable_count
//   enable_count  advance enable, active high
//   count         current phase count
//   tick          registered one-cycle pulse in the cycle count changes
//   saturated     high while count == 15
module phase_timer #(
   parameter int unsigned PRESCALE = 50000000,
   parameter int unsigned PS_WIDTH = 26
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       reset_count,
   input  logic       enable_count,
   output logic [3:0] count,
   output logic       tick,
   output logic       saturated
);

   localparam logic [PS_WIDTH-1:0] PsLast   = PS_WIDTH'(PRESCALE - 1);
   localparam logic [3:0]          CountMax = 4'd15;

   typedef enum logic [1:0] {
      StCleared   = 2'd0,
      StRunning   = 2'd1,
      StSaturated = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [PS_WIDTH-1:0] ps_q, ps_d;
   logic [3:0]          count_q, count_d;
   logic                tick_q, tick_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StCleared;
         ps_q    <= '0;
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ps_q    <= ps_d;
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ps_d    = ps_q;
      count_d = count_q;
      tick_d  = 1'b0;

      if (reset_count) begin
         state_d = StCleared;
         ps_d    = '0;
         count_d = '0;
      end else if (enable_count) begin
         if (ps_q == PsLast) begin
            ps_d = '0;
            // At 15 the step is swallowed: no count change, so no tick.
            if (count_q != CountMax) begin
               count_d = count_q + 4'd1;
               tick_d  = 1'b1;
               state_d = (count_q == CountMax - 4'd1) ? StSaturated : StRunning;
            end
         end else begin
            ps_d = ps_q + 1'b1;
         end
      end
      // enable_count low: prescaler phase is kept so a resumed step is not restarted.
   end

   assign count     = count_q;
   assign tick      = tick_q;
   assign saturated = (state_q == StSaturated);

endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer
//   Drives a PRESCALE=4 and a PRESCALE=1 phase_timer with the same inputs and
//   compares both against a model that tracks enabled edges since the last clear.
module tb_phase_timer;

   logic       clock = 1'b0;
   logic       reset;
   logic       reset_count;
   logic       enable_count;
   logic [3:0] count4, count1;
   logic       tick4, tick1;
   logic       sat4, sat1;

   always #5 clock = ~clock;

   phase_timer #(.PRESCALE(4), .PS_WIDTH(3)) u_dut4 (
      .clock        (clock),
      .reset        (reset),
      .reset_count  (reset_count),
      .enable_count (enable_count),
      .count        (count4),
      .tick         (tick4),
      .saturated    (sat4)
   );

   phase_timer #(.PRESCALE(1), .PS_WIDTH(1)) u_dut1 (
      .clock        (clock),
      .reset        (reset),
      .reset_count  (reset_count),
      .enable_count (enable_count),
      .count        (count1),
      .tick         (tick1),
      .saturated    (sat1)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Model: enabled edges since the last clear/reset, and whether this edge stepped.
   int unsigned e4 = 0, e1 = 0;
   logic        tk4_exp = 1'b0, tk1_exp = 1'b0;
   int unsigned tick_seen;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int unsigned exp_count(input int unsigned e, input int unsigned p);
      return (e / p > 15) ? 15 : e / p;
   endfunction

   task automatic check_all(input string tag);
      check_eq({tag, " count4"}, 32'(count4), exp_count(e4, 4));
      check_eq({tag, " tick4"},  32'(tick4),  32'(tk4_exp));
      check_eq({tag, " sat4"},   32'(sat4),   32'(exp_count(e4, 4) == 15));
      check_eq({tag, " count1"}, 32'(count1), exp_count(e1, 1));
      check_eq({tag, " tick1"},  32'(tick1),  32'(tk1_exp));
      check_eq({tag, " sat1"},   32'(sat1),   32'(exp_count(e1, 1) == 15));
   endtask

   task automatic cycle(input string tag, input logic rc, input logic en);
      @(negedge clock);
      reset_count  = rc;
      enable_count = en;
      @(posedge clock);
      if (rc) begin
         e4 = 0; e1 = 0; tk4_exp = 1'b0; tk1_exp = 1'b0;
      end else if (en) begin
         e4++; e1++;
         tk4_exp = (e4 % 4 == 0) && (e4 / 4 <= 15);
         tk1_exp = (e1 <= 15);
      end else begin
         tk4_exp = 1'b0; tk1_exp = 1'b0;
      end
      #1;
      check_all(tag);
   endtask

   task automatic run(input string tag, input int unsigned n, input logic en);
      for (int i = 0; i < n; i++) begin
         cycle(tag, 1'b0, en);
         if (tick4) tick_seen++;
      end
   endtask

   // Assert reset away from any edge, check outputs before the next edge, then release.
   task automatic async_reset(input string tag);
      @(negedge clock);
      reset_count  = 1'b0;
      enable_count = 1'b0;
      #2 reset = 1'b0;
      e4 = 0; e1 = 0; tk4_exp = 1'b0; tk1_exp = 1'b0;
      #1;
      check_all(tag);
      @(negedge clock);
      #2 reset = 1'b1;
   endtask

   initial begin
      reset        = 1'b0;
      reset_count  = 1'b0;
      enable_count = 1'b0;
      tick_seen    = 0;
      #1;
      check_all("por");
      @(negedge clock);
      #2 reset = 1'b1;

      // Count up to 5, then async reset clears immediately.
      cycle("t1clr", 1'b1, 1'b0);
      run("t1run", 20, 1'b1);
      check_eq("t1 count before reset", 32'(count4), 32'd5);
      async_reset("t1async");

      // Clear pulse followed by 32 enabled edges: eight ticks, count 8.
      cycle("t2clr", 1'b1, 1'b0);
      tick_seen = 0;
      run("t2run", 32, 1'b1);
      check_eq("t2 tick pulses", tick_seen, 32'd8);
      check_eq("t2 final count", 32'(count4), 32'd8);

      // Enable 6, disable 10, re-enable 2: prescaler phase survives the pause.
      cycle("t3clr", 1'b1, 1'b0);
      run("t3en", 6, 1'b1);
      run("t3dis", 10, 1'b0);
      run("t3re", 2, 1'b1);
      check_eq("t3 count after resume", 32'(count4), 32'd2);

      // Saturation at edge 60, held through edge 70.
      cycle("t4clr", 1'b1, 1'b0);
      run("t4run", 70, 1'b1);
      check_eq("t4 saturated", 32'(sat4), 32'd1);

      // Clear with enable at ps==3, then a full step is needed.
      cycle("t5clr", 1'b1, 1'b0);
      run("t5pre", 3, 1'b1);
      cycle("t5both", 1'b1, 1'b1);
      run("t5post", 4, 1'b1);
      check_eq("t5 step after clear", 32'(count4), 32'd1);

      // Held clear keeps count and tick at zero.
      for (int i = 0; i < 4; i++) cycle("heldclr", 1'b1, 1'b1);

      // Async reset mid-step discards partial prescale.
      run("t6pre", 22, 1'b1);
      async_reset("t6async");
      run("t6post", 4, 1'b1);
      check_eq("t6 full step after reset", 32'(count4), 32'd1);

      // Randomized traffic, biased toward long enabled runs.
      for (int i = 0; i < 600; i++) begin
         cycle("rand", ($urandom_range(99) < 3), ($urandom_range(99) < 80));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
